// File: rtl/sha256_k_machine.sv
// Free-running SHA-256 round-constant sequencer: K[round] on registered outputs.
// Define SHA256_K_HOLD_EN to saturate at round 63 instead of wrapping to 0.
module sha256_k_machine (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] K,
  output logic [5:0]  round,
  output logic        last
);

  // FIPS 180-4 round constants, read-only.
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [5:0] round_next;

  always_comb begin
`ifdef SHA256_K_HOLD_EN
    round_next = (round == 6'd63) ? round : round + 6'd1;
`else
    round_next = round + 6'd1;
`endif
  end

  // K and last are looked up from the next index so all three outputs move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      round <= 6'd0;
      K     <= K_ROM[0];
      last  <= 1'b0;
    end else begin
      round <= round_next;
      K     <= K_ROM[round_next];
      last  <= (round_next == 6'd63);
    end
  end

endmodule

// File: tb/tb_sha256_k_machine.sv
// Scoreboard bench for sha256_k_machine; expectations come from a round model and the
// published constant table. Define SHA256_K_HOLD_EN here too to check the saturating build.
module tb_sha256_k_machine;

  logic        clk;
  logic        rst;
  logic [31:0] K;
  logic [5:0]  round;
  logic        last;

  sha256_k_machine dut (
    .clk   (clk),
    .rst   (rst),
    .K     (K),
    .round (round),
    .last  (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  r;
    logic [31:0] k;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] golden [64];
  int          vectors = 0;
  int          miscompares = 0;
  int          model_round = 0;
  bit          driver_done = 0;

  initial begin
    golden = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
  end

  // One clock edge with rst driven to r; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    @(posedge clk);
    if (r)
      model_round = 0;
`ifdef SHA256_K_HOLD_EN
    else if (model_round == 63)
      model_round = 63;
`endif
    else
      model_round = (model_round + 1) % 64;
    e.r = 6'(model_round);
    e.k = golden[model_round];
    e.l = (model_round == 63);
    #1;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    step(1'b1);                 // first reset edge
    repeat (3) step(1'b1);      // reset held
    run(70);                    // full table, then wrap or hold through edge 70
    step(1'b1);
    run(20);                    // now at round 20
    step(1'b1);                 // mid-run reset
    run(63);                    // now at round 63
    step(1'b1);                 // reset from the last round
    run(3);
    @(negedge clk);
    @(negedge clk);
    driver_done = 1;
  end

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (K !== e.k || round !== e.r || last !== e.l) begin
          miscompares++;
          $display("FAIL vec%0d: got K=%08h round=%0d last=%b, want K=%08h round=%0d last=%b",
                   vectors, K, round, last, e.k, e.r, e.l);
        end else begin
          $display("vec%0d ok: K=%08h round=%0d last=%b", vectors, K, round, last);
        end
      end
    end
  end

  // Literal spot checks of the golden table against the hand-listed constants.
  initial begin
    logic [31:0] spot_k [10];
    int          spot_i [10];
    spot_k = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h14292967,
               32'h27b70a85, 32'h19a4c116, 32'h748f82ee, 32'hbef9a3f7, 32'hc67178f2};
    spot_i = '{0, 1, 2, 3, 31, 32, 48, 56, 62, 63};
    #2;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (golden[spot_i[i]] !== spot_k[i]) begin
        miscompares++;
        $display("FAIL table[%0d]: got %08h, want %08h", spot_i[i], golden[spot_i[i]], spot_k[i]);
      end
    end
  end

  initial begin
    fork
      wait (driver_done);
      #20000;
    join_any
    if (!driver_done || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending (done=%0d), want 0 pending (done=1)", sb.size(), driver_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
